// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions: colour codes, board size, the field layout
// of the controller's write request word, and the piece-drawer state enum.
package connect4_pkg;

    // 3-bit RGB colour codes understood by the VGA adapter.
    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] WHITE  = 3'b111;
    localparam logic [2:0] BLUE   = 3'b001;

    // Board dimensions, sized to compare directly against 3-bit row/col fields.
    localparam logic [2:0] ROWS = 3'd6;
    localparam logic [2:0] COLS = 3'd7;

    // Request word layout: {req, row[2:0], col[2:0], player[1:0]}.
    localparam int REQ_W   = 9;
    localparam int REQ_BIT = 8;
    localparam int ROW_HI  = 7;
    localparam int ROW_LO  = 5;
    localparam int COL_HI  = 4;
    localparam int COL_LO  = 2;
    localparam int PLY_HI  = 1;
    localparam int PLY_LO  = 0;

    // VGA plot port widths for the 160x120 adapter.
    localparam int VGA_X_W  = 8;
    localparam int VGA_Y_W  = 7;
    localparam int COLOUR_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLOT,
        S_DONE,
        S_RELEASE
    } draw_state_t;

    // Interior fill colour for a piece owned by the given player.
    function automatic logic [2:0] player_colour(input logic [1:0] player);
        logic [2:0] c;
        c = BLACK;
        case (player)
            2'd0:    c = BLACK;
            2'd1:    c = RED;
            2'd2:    c = YELLOW;
            default: c = WHITE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/piece_drawer_if.sv
// Write-request / plot bundle between the game controller, the piece drawer
// and the VGA adapter.
//   master : game-controller side, drives write_to_ram, observes the rest.
//   slave  : piece drawer, consumes write_to_ram, drives status and plot port.
interface piece_drawer_if;
    import connect4_pkg::*;

    logic [REQ_W-1:0]    write_to_ram;
    logic                draw_done;
    logic                busy;
    logic [VGA_X_W-1:0]  vga_x;
    logic [VGA_Y_W-1:0]  vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                plot;
    logic                err;

    modport master (
        output write_to_ram,
        input  draw_done, busy, vga_x, vga_y, vga_colour, plot, err
    );

    modport slave (
        input  write_to_ram,
        output draw_done, busy, vga_x, vga_y, vga_colour, plot, err
    );

endinterface

// File: rtl/cell_scan_counter.sv
// Nested raster counter over one square cell: cx runs 0..2^W-1, and cy
// steps each time cx wraps. Shared with the board-clear sweep.
// Ports:
//   clk, resetn   clock, asynchronous active-high reset
//   clear_i       force cx = cy = 0 (wins over en_i)
//   en_i          advance one pixel
//   cx_o, cy_o    current position
//   last_o        position is the final pixel (both counters at max)
//   edge_o        position lies on the cell border
module cell_scan_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clear_i,
    input  logic         en_i,
    output logic [W-1:0] cx_o,
    output logic [W-1:0] cy_o,
    output logic         last_o,
    output logic         edge_o
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] cx_q, cx_d;
    logic [W-1:0] cy_q, cy_d;

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (clear_i) begin
            cx_d = '0;
            cy_d = '0;
        end else if (en_i) begin
            cx_d = cx_q + W'(1);
            if (cx_q == MAX) begin
                cy_d = cy_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign cx_o   = cx_q;
    assign cy_o   = cy_q;
    assign last_o = (cx_q == MAX) && (cy_q == MAX);
    assign edge_o = (cx_q == '0) || (cx_q == MAX) || (cy_q == '0) || (cy_q == MAX);

endmodule

// File: rtl/piece_drawer.sv
// Renders one board cell per controller request as a CELL x CELL square on
// the VGA plot port, then pulses draw_done.
// Ports:
//   clk      system clock
//   resetn   asynchronous reset, active HIGH despite the name
//   bus      piece_drawer_if.slave: write_to_ram in; draw_done, busy,
//            vga_x, vga_y, vga_colour, plot, err out
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for req; fields latched on acceptance
// S_LOAD    | range check, register cell origin
// S_PLOT    | one pixel per cycle, raster order
// S_DONE    | draw_done pulse
// S_RELEASE | request still held; wait for req to drop
module piece_drawer
    import connect4_pkg::*;
#(
    parameter int unsigned CELL_LOG2 = 4,
    parameter int unsigned X0        = 24,
    parameter int unsigned Y0        = 12
) (
    input  logic             clk,
    input  logic             resetn,
    piece_drawer_if.slave    bus
);

    draw_state_t    state_q;
    logic [2:0]     row_q;
    logic [2:0]     col_q;
    logic [1:0]     player_q;
    logic [7:0]     ox_q, ox_d;
    logic [6:0]     oy_q, oy_d;
    logic           pix_last_q;

    logic           draw_done_q;
    logic           busy_q;
    logic           plot_q;
    logic           err_q;
    logic [7:0]     vga_x_q;
    logic [6:0]     vga_y_q;
    logic [2:0]     vga_colour_q;

    logic                 req;
    logic                 in_range;
    logic                 scan_clear;
    logic                 scan_en;
    logic [CELL_LOG2-1:0] scan_cx;
    logic [CELL_LOG2-1:0] scan_cy;
    logic                 scan_last;
    logic                 scan_edge;
    logic [2:0]           nxt_colour;

    assign req      = bus.write_to_ram[REQ_BIT];
    assign in_range = (row_q < ROWS) && (col_q < COLS);
    assign ox_d     = 8'(X0) + (8'(col_q) << CELL_LOG2);
    assign oy_d     = 7'(Y0) + (7'(row_q) << CELL_LOG2);

    // The scan counter runs one pixel ahead of the output registers: it is
    // cleared on acceptance, so during LOAD it already addresses pixel 0 and
    // the output registers can be loaded directly from it on every edge.
    assign scan_clear = (state_q == S_IDLE) && req;
    assign scan_en    = ((state_q == S_LOAD) && in_range) ||
                        ((state_q == S_PLOT) && !pix_last_q);

    cell_scan_counter #(
        .W (CELL_LOG2)
    ) u_scan (
        .clk     (clk),
        .resetn  (resetn),
        .clear_i (scan_clear),
        .en_i    (scan_en),
        .cx_o    (scan_cx),
        .cy_o    (scan_cy),
        .last_o  (scan_last),
        .edge_o  (scan_edge)
    );

    assign nxt_colour = scan_edge ? BLUE : player_colour(player_q);

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            player_q     <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
            pix_last_q   <= 1'b0;
            draw_done_q  <= 1'b0;
            busy_q       <= 1'b0;
            plot_q       <= 1'b0;
            err_q        <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
        end else begin
            draw_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        row_q    <= bus.write_to_ram[ROW_HI:ROW_LO];
                        col_q    <= bus.write_to_ram[COL_HI:COL_LO];
                        player_q <= bus.write_to_ram[PLY_HI:PLY_LO];
                        busy_q   <= 1'b1;
                        state_q  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!in_range) begin
                        err_q       <= 1'b1;
                        draw_done_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        ox_q         <= ox_d;
                        oy_q         <= oy_d;
                        plot_q       <= 1'b1;
                        vga_x_q      <= ox_d + 8'(scan_cx);
                        vga_y_q      <= oy_d + 7'(scan_cy);
                        vga_colour_q <= nxt_colour;
                        pix_last_q   <= scan_last;
                        state_q      <= S_PLOT;
                    end
                end
                S_PLOT: begin
                    if (pix_last_q) begin
                        plot_q       <= 1'b0;
                        vga_x_q      <= '0;
                        vga_y_q      <= '0;
                        vga_colour_q <= '0;
                        pix_last_q   <= 1'b0;
                        draw_done_q  <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        vga_x_q      <= ox_q + 8'(scan_cx);
                        vga_y_q      <= oy_q + 7'(scan_cy);
                        vga_colour_q <= nxt_colour;
                        pix_last_q   <= scan_last;
                    end
                end
                S_DONE: begin
                    if (req) begin
                        state_q <= S_RELEASE;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_RELEASE: begin
                    if (!req) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    plot_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.draw_done  = draw_done_q;
    assign bus.busy       = busy_q;
    assign bus.plot       = plot_q;
    assign bus.err        = err_q;
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;

endmodule

// File: tb/tb_piece_drawer.sv
module tb_piece_drawer;

    typedef struct {
        int cyc;
        int x;
        int y;
        int c;
    } pix_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   cyc    = 0;

    int   n_pass  = 0;
    int   n_total = 0;

    pix_t exp_pix[$];
    int   exp_done[$];

    int   cap_x[256];
    int   cap_y[256];
    int   cap_c[256];
    int   cap_n     = 0;
    int   done_seen = 0;
    int   pcol[4]   = '{0, 4, 6, 7};

    piece_drawer_if bus ();

    piece_drawer dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compares every plotted pixel and every draw_done against the scoreboard.
    always @(negedge clk) begin
        pix_t e;
        if (!resetn) begin
            if (bus.plot) begin
                if (exp_pix.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_plot: got plot at (%0d,%0d) cycle %0d, expected none",
                             bus.vga_x, bus.vga_y, cyc);
                end else begin
                    e = exp_pix.pop_front();
                    n_total++;
                    if (cyc == e.cyc && int'(bus.vga_x) == e.x && int'(bus.vga_y) == e.y &&
                        int'(bus.vga_colour) == e.c)
                        n_pass++;
                    else
                        $display("FAIL pixel: got cyc %0d (%0d,%0d) colour %0d, expected cyc %0d (%0d,%0d) colour %0d",
                                 cyc, bus.vga_x, bus.vga_y, bus.vga_colour, e.cyc, e.x, e.y, e.c);
                end
                if (cap_n < 256) begin
                    cap_x[cap_n] = int'(bus.vga_x);
                    cap_y[cap_n] = int'(bus.vga_y);
                    cap_c[cap_n] = int'(bus.vga_colour);
                end
                cap_n++;
            end
            if (bus.draw_done) begin
                done_seen++;
                if (exp_done.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: got draw_done at cycle %0d, expected none", cyc);
                end else begin
                    check("draw_done_cycle", cyc, exp_done.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // Issue a request; cycle n of this request (edge 0 = acceptance) has cyc == base + n.
    task automatic send(input int r, input int c, input int p, input bit hold, output int base);
        base = cyc;
        cap_n = 0;
        bus.write_to_ram = {1'b1, 3'(r), 3'(c), 2'(p)};
        if (r < 6 && c < 7) begin
            for (int i = 0; i < 256; i++) begin
                pix_t e;
                int px;
                int py;
                px = i % 16;
                py = i / 16;
                e.cyc = base + 2 + i;
                e.x   = 24 + 16 * c + px;
                e.y   = 12 + 16 * r + py;
                e.c   = (px == 0 || px == 15 || py == 0 || py == 15) ? 1 : pcol[p];
                exp_pix.push_back(e);
            end
            exp_done.push_back(base + 258);
        end else begin
            exp_done.push_back(base + 2);
        end
        tick();
        check("busy_in_load", int'(bus.busy), 1);
        check("plot_in_load", int'(bus.plot), 0);
        if (!hold) bus.write_to_ram[8] = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (exp_done.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        if (exp_done.size() != 0) begin
            n_total++;
            $display("FAIL %s_timeout: draw_done still pending after %0d cycles, expected within 400", name, n);
            exp_done.delete();
            exp_pix.delete();
        end
        tick();
        tick();
    endtask

    task automatic check_pix(input string name, input int idx, input int x, input int y, input int c);
        check({name, "_x"}, cap_x[idx], x);
        check({name, "_y"}, cap_y[idx], y);
        check({name, "_colour"}, cap_c[idx], c);
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int d0;
        bus.write_to_ram = '0;
        #2 resetn = 1'b1;
        tick();
        tick();
        check("rst_plot", int'(bus.plot), 0);
        check("rst_x", int'(bus.vga_x), 0);
        check("rst_y", int'(bus.vga_y), 0);
        check("rst_colour", int'(bus.vga_colour), 0);
        check("rst_done", int'(bus.draw_done), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_err", int'(bus.err), 0);
        resetn = 1'b0;
        tick();
        tick();

        // Row 0, col 0, red.
        send(0, 0, 1, 1'b0, b);
        wait_done("t1");
        check("t1_count", cap_n, 256);
        check_pix("t1_first", 0, 24, 12, 1);
        check_pix("t1_inner", 17, 25, 13, 4);
        check_pix("t1_last", 255, 39, 27, 1);
        check("t1_busy_after", int'(bus.busy), 0);
        check("t1_err", int'(bus.err), 0);

        // Bottom-right cell, yellow.
        send(5, 6, 2, 1'b0, b);
        wait_done("t2");
        check("t2_count", cap_n, 256);
        check_pix("t2_first", 0, 120, 92, 1);
        check_pix("t2_inner", 17, 121, 93, 6);
        check_pix("t2_last", 255, 135, 107, 1);
        check("t2_err", int'(bus.err), 0);

        // Out-of-range row.
        send(6, 3, 0, 1'b0, b);
        check("t3_err_cycle1", int'(bus.err), 0);
        tick();
        check("t3_err_cycle2", int'(bus.err), 1);
        wait_done("t3");
        check("t3_count", cap_n, 0);

        // Valid request afterwards: black interior, err stays set.
        send(3, 1, 0, 1'b0, b);
        wait_done("t4");
        check("t4_count", cap_n, 256);
        check_pix("t4_inner", 17, 41, 61, 0);
        check("t4_err_sticky", int'(bus.err), 1);

        // Request held for 600 cycles.
        d0 = done_seen;
        send(1, 2, 3, 1'b1, b);
        while (cyc < b + 400) tick();
        check("t5_busy_held", int'(bus.busy), 1);
        check("t5_done_once", done_seen - d0, 1);
        while (cyc < b + 600) tick();
        bus.write_to_ram = '0;
        tick();
        check("t5_busy_released", int'(bus.busy), 0);
        check("t5_count", cap_n, 256);
        check("t5_done_total", done_seen - d0, 1);

        // Fields change and req drops during PLOT; original cell is drawn.
        send(2, 3, 3, 1'b1, b);
        while (cyc < b + 50) tick();
        bus.write_to_ram = {1'b1, 3'd2, 3'd0, 2'd0};
        while (cyc < b + 120) tick();
        bus.write_to_ram = {1'b0, 3'd2, 3'd0, 2'd0};
        wait_done("t6");
        check("t6_count", cap_n, 256);
        check_pix("t6_inner", 17, 73, 45, 7);
        check_pix("t6_last", 255, 87, 59, 1);

        // Reset in PLOT cycle 100.
        send(4, 4, 1, 1'b0, b);
        while (cyc < b + 101) tick();
        resetn = 1'b1;
        #1;
        check("t7_plot", int'(bus.plot), 0);
        check("t7_x", int'(bus.vga_x), 0);
        check("t7_y", int'(bus.vga_y), 0);
        check("t7_colour", int'(bus.vga_colour), 0);
        check("t7_done", int'(bus.draw_done), 0);
        check("t7_busy", int'(bus.busy), 0);
        check("t7_err", int'(bus.err), 0);
        check("t7_plotted_before_reset", cap_n, 99);
        exp_pix.delete();
        exp_done.delete();
        tick();
        tick();
        resetn = 1'b0;
        tick();
        send(0, 6, 2, 1'b0, b);
        wait_done("t8");
        check("t8_count", cap_n, 256);
        check_pix("t8_first", 0, 120, 12, 1);
        check_pix("t8_inner", 17, 121, 13, 6);

        check("sb_pix_empty", exp_pix.size(), 0);
        check("sb_done_empty", exp_done.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
